// File: rtl/mem_port_arbiter_if.sv
// Bundle of the fetch requester, data requester and RAM-side signals of mem_port_arbiter.
// slave is the arbiter's view; master is the view of everything around it (core + RAM).
interface mem_port_arbiter_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    // fetch requester
    logic                    if_req;
    logic [ADDR_WIDTH-1:0]   if_addr;
    logic                    if_ready;
    logic                    if_rvalid;
    logic [DATA_WIDTH-1:0]   if_rdata;

    // data requester
    logic                    d_req;
    logic                    d_we;
    logic [ADDR_WIDTH-1:0]   d_addr;
    logic [DATA_WIDTH-1:0]   d_wdata;
    logic [3:0]              d_wstrb;
    logic                    d_ready;
    logic                    d_rvalid;
    logic [DATA_WIDTH-1:0]   d_rdata;

    // RAM side
    logic                    mem_en;
    logic [3:0]              mem_we;
    logic [ADDR_WIDTH-3:0]   mem_addr;
    logic [DATA_WIDTH-1:0]   mem_wdata;
    logic [DATA_WIDTH-1:0]   mem_rdata;

    modport slave (
        input  if_req, if_addr,
        input  d_req, d_we, d_addr, d_wdata, d_wstrb,
        input  mem_rdata,
        output if_ready, if_rvalid, if_rdata,
        output d_ready, d_rvalid, d_rdata,
        output mem_en, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output if_req, if_addr,
        output d_req, d_we, d_addr, d_wdata, d_wstrb,
        output mem_rdata,
        input  if_ready, if_rvalid, if_rdata,
        input  d_ready, d_rvalid, d_rdata,
        input  mem_en, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one single-port word-addressed RAM between instruction fetch and load/store.
// Data wins by default; a starvation counter forces a fetch grant after STARVE_LIMIT denials.
module mem_port_arbiter #(
    parameter int ADDR_WIDTH   = 32,
    parameter int DATA_WIDTH   = 32,  // must be 32: four byte strobes
    parameter int STARVE_LIMIT = 4    // 1..15
) (
    input  logic                 clk,
    input  logic                 rst_n,
    mem_port_arbiter_if.slave    bus,
    output logic [3:0]           dbg_starve_cnt,
    output logic [1:0]           dbg_resp_owner
);

    // Handshake: a request transfers when req && ready in the same cycle; requesters
    // hold req/addr/we/wdata stable until then. Read responses (rvalid/rdata) arrive
    // exactly one cycle after acceptance and cannot be back-pressured.

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_IF   = 2'd1,
        OWN_D    = 2'd2
    } owner_e;

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    owner_e      resp_owner, resp_owner_next;
    logic [3:0]  starve_cnt, starve_cnt_next;
    logic        grant_if, grant_d;

    logic unused_addr_bits;
    assign unused_addr_bits = ^{bus.if_addr[1:0], bus.d_addr[1:0]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            resp_owner <= OWN_NONE;
            starve_cnt <= 4'd0;
        end else begin
            resp_owner <= resp_owner_next;
            starve_cnt <= starve_cnt_next;
        end
    end

    always_comb begin
        grant_if        = 1'b0;
        grant_d         = 1'b0;
        resp_owner_next = OWN_NONE;
        starve_cnt_next = 4'd0;

        bus.if_ready    = 1'b0;
        bus.d_ready     = 1'b0;
        bus.mem_en      = 1'b0;
        bus.mem_we      = 4'b0000;
        bus.mem_addr    = '0;
        bus.mem_wdata   = '0;
        bus.if_rvalid   = 1'b0;
        bus.if_rdata    = '0;
        bus.d_rvalid    = 1'b0;
        bus.d_rdata     = '0;

        // Fetch only wins a contested cycle once it has waited LIMIT cycles.
        grant_if = bus.if_req && (!bus.d_req || (starve_cnt >= LIMIT));
        grant_d  = bus.d_req && !grant_if;

        bus.if_ready = grant_if;
        bus.d_ready  = grant_d;
        bus.mem_en   = grant_if || grant_d;

        if (grant_if) begin
            bus.mem_addr    = bus.if_addr[ADDR_WIDTH-1:2];
            resp_owner_next = OWN_IF;
        end else if (grant_d) begin
            bus.mem_addr    = bus.d_addr[ADDR_WIDTH-1:2];
            bus.mem_wdata   = bus.d_wdata;
            bus.mem_we      = bus.d_we ? bus.d_wstrb : 4'b0000;
            resp_owner_next = bus.d_we ? OWN_NONE : OWN_D;
        end

        if (bus.if_req && !grant_if) begin
            starve_cnt_next = (starve_cnt >= LIMIT) ? LIMIT : starve_cnt + 4'd1;
        end

        // Only the port that issued last cycle's read sees RAM data.
        case (resp_owner)
            OWN_IF: begin
                bus.if_rvalid = 1'b1;
                bus.if_rdata  = bus.mem_rdata;
            end
            OWN_D: begin
                bus.d_rvalid = 1'b1;
                bus.d_rdata  = bus.mem_rdata;
            end
            default: ;
        endcase
    end

    assign dbg_starve_cnt = starve_cnt;
    assign dbg_resp_owner = resp_owner;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: RAM stub, spec-level reference model checked every
// cycle, and hand-computed literal checks along the directed sequence.
module tb_mem_port_arbiter;

  localparam int AW           = 32;
  localparam int DW           = 32;
  localparam int STARVE_LIMIT = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] dbg_starve_cnt;
  logic [1:0] dbg_resp_owner;

  int tests_run = 0;
  int failed    = 0;

  mem_port_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  mem_port_arbiter #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .STARVE_LIMIT(STARVE_LIMIT)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus),
    .dbg_starve_cnt(dbg_starve_cnt), .dbg_resp_owner(dbg_resp_owner)
  );

  always #5 clk = ~clk;

  // ---------------- RAM stub driven by the DUT ----------------
  logic [31:0] ram [64];

  always @(posedge clk) begin
    if (bus.mem_en) begin
      if (bus.mem_we == 4'b0000) begin
        bus.mem_rdata <= ram[bus.mem_addr[5:0]];
      end else begin
        for (int b = 0; b < 4; b++)
          if (bus.mem_we[b]) ram[bus.mem_addr[5:0]][8*b +: 8] <= bus.mem_wdata[8*b +: 8];
      end
    end
  end

  // ---------------- checker ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [31:0] model_ram [64];
  int          m_wait      = 0;      // consecutive denied fetch cycles
  logic [31:0] exp_q[$];             // read data owed next cycle (0 or 1 entry)
  bit          m_pend_if   = 0;
  bit          m_pend_d    = 0;

  always @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_wait    = 0;
      m_pend_if = 0;
      m_pend_d  = 0;
      exp_q.delete();
    end else begin
      bit          e_if, e_d;
      logic [31:0] e_addr, e_we, e_data, rd;
      int          w;

      // responses owed from last cycle
      rd = (exp_q.size() > 0) ? exp_q.pop_front() : 32'h0;
      check("m_if_rvalid", 32'(bus.if_rvalid), 32'(m_pend_if));
      check("m_d_rvalid",  32'(bus.d_rvalid),  32'(m_pend_d));
      check("m_if_rdata",  bus.if_rdata, m_pend_if ? rd : 32'h0);
      check("m_d_rdata",   bus.d_rdata,  m_pend_d  ? rd : 32'h0);
      check("m_starve",    32'(dbg_starve_cnt), 32'(m_wait));

      // this cycle's grant from the priority rules
      e_if = bus.if_req && (!bus.d_req || m_wait == STARVE_LIMIT);
      e_d  = bus.d_req && !e_if;
      e_addr = e_if ? 32'(bus.if_addr >> 2) : (e_d ? 32'(bus.d_addr >> 2) : 32'h0);
      e_we   = (e_d && bus.d_we) ? 32'(bus.d_wstrb) : 32'h0;
      check("m_if_ready", 32'(bus.if_ready), 32'(e_if));
      check("m_d_ready",  32'(bus.d_ready),  32'(e_d));
      check("m_mem_en",   32'(bus.mem_en),   32'(e_if || e_d));
      check("m_mem_addr", 32'(bus.mem_addr), e_addr);
      check("m_mem_we",   32'(bus.mem_we),   e_we);
      if (!e_if) check("m_mem_wdata", bus.mem_wdata, e_d ? bus.d_wdata : 32'h0);

      // advance the model
      m_wait = (bus.if_req && !e_if) ? ((m_wait + 1 > STARVE_LIMIT) ? STARVE_LIMIT : m_wait + 1) : 0;
      w = int'(e_addr[5:0]);
      m_pend_if = e_if;
      m_pend_d  = e_d && !bus.d_we;
      if (e_if || m_pend_d) exp_q.push_back(model_ram[w]);
      if (e_d && bus.d_we) begin
        e_data = model_ram[w];
        for (int b = 0; b < 4; b++)
          if (bus.d_wstrb[b]) e_data[8*b +: 8] = bus.d_wdata[8*b +: 8];
        model_ram[w] = e_data;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.if_req  = 1'b0; bus.if_addr = '0;
    bus.d_req   = 1'b0; bus.d_we    = 1'b0; bus.d_addr = '0;
    bus.d_wdata = '0;   bus.d_wstrb = 4'b0000;
  endtask

  task automatic drive_if(input logic [31:0] addr);
    bus.if_req  = 1'b1;
    bus.if_addr = addr;
  endtask

  task automatic drive_d(input logic we, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [3:0] strb);
    bus.d_req   = 1'b1;
    bus.d_we    = we;
    bus.d_addr  = addr;
    bus.d_wdata = wdata;
    bus.d_wstrb = strb;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    for (int i = 0; i < 64; i++) begin
      ram[i]       = 32'h0;
      model_ram[i] = 32'h0;
    end
    ram[4]        = 32'hDEADBEEF;
    model_ram[4]  = 32'hDEADBEEF;
    bus.mem_rdata = 32'h0;
    idle();

    // reset state
    repeat (2) @(negedge clk);
    check("rst_if_rvalid", 32'(bus.if_rvalid), 32'h0);
    check("rst_d_rvalid",  32'(bus.d_rvalid),  32'h0);
    check("rst_if_rdata",  bus.if_rdata, 32'h0);
    check("rst_d_rdata",   bus.d_rdata,  32'h0);
    check("rst_starve",    32'(dbg_starve_cnt), 32'h0);
    check("rst_mem_en",    32'(bus.mem_en), 32'h0);
    tick();
    rst_n = 1'b1;

    // fetch-only read of word 4
    tick();
    drive_if(32'h10);
    @(negedge clk);
    check("f_if_ready", 32'(bus.if_ready), 32'h1);
    check("f_mem_addr", 32'(bus.mem_addr), 32'h4);
    tick();
    idle();
    @(negedge clk);
    check("f_if_rvalid", 32'(bus.if_rvalid), 32'h1);
    check("f_if_rdata",  bus.if_rdata, 32'hDEADBEEF);
    check("f_d_rvalid",  32'(bus.d_rvalid), 32'h0);

    // strobed write then immediate read of the same word
    tick();
    drive_d(1'b1, 32'h20, 32'h11223344, 4'b0101);
    @(negedge clk);
    check("w_d_ready", 32'(bus.d_ready), 32'h1);
    check("w_mem_we",  32'(bus.mem_we), 32'h5);
    tick();
    drive_d(1'b0, 32'h20, 32'h0, 4'b0000);
    @(negedge clk);
    check("w_no_rvalid", 32'(bus.d_rvalid), 32'h0);
    tick();
    idle();
    @(negedge clk);
    check("r_d_rvalid", 32'(bus.d_rvalid), 32'h1);
    check("r_d_rdata",  bus.d_rdata, 32'h00220044);

    // both requesting continuously: D,D,D,D,IF repeating
    tick();
    drive_if(32'h10);
    drive_d(1'b0, 32'h20, 32'h0, 4'b0000);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      check($sformatf("s_d_ready_%0d", k),  32'(bus.d_ready),  32'((k % 5) != 4));
      check($sformatf("s_if_ready_%0d", k), 32'(bus.if_ready), 32'((k % 5) == 4));
      if (k == 4) check("s_starve_at_grant", 32'(dbg_starve_cnt), 32'h4);
      if (k == 5) check("s_starve_cleared",  32'(dbg_starve_cnt), 32'h0);
      tick();
    end
    idle();

    // alternating read grants IF, D, IF
    drive_if(32'h10);
    @(negedge clk);
    tick();
    idle();
    drive_d(1'b0, 32'h20, 32'h0, 4'b0000);
    @(negedge clk);
    check("a_if_rvalid", 32'(bus.if_rvalid), 32'h1);
    check("a_if_rdata",  bus.if_rdata, 32'hDEADBEEF);
    check("a_d_rdata0",  bus.d_rdata, 32'h0);
    tick();
    idle();
    drive_if(32'h10);
    @(negedge clk);
    check("a_d_rvalid", 32'(bus.d_rvalid), 32'h1);
    check("a_d_rdata",  bus.d_rdata, 32'h00220044);
    check("a_if_rdata0", bus.if_rdata, 32'h0);
    tick();
    idle();
    @(negedge clk);
    check("a_if_rvalid2", 32'(bus.if_rvalid), 32'h1);

    // write with zero strobes leaves RAM untouched
    tick();
    drive_d(1'b1, 32'h10, 32'hFFFFFFFF, 4'b0000);
    @(negedge clk);
    check("z_d_ready", 32'(bus.d_ready), 32'h1);
    check("z_mem_en",  32'(bus.mem_en), 32'h1);
    check("z_mem_we",  32'(bus.mem_we), 32'h0);
    tick();
    idle();
    drive_if(32'h10);
    @(negedge clk);
    check("z_no_rvalid", 32'(bus.d_rvalid), 32'h0);
    tick();
    idle();
    @(negedge clk);
    check("z_ram_kept", bus.if_rdata, 32'hDEADBEEF);

    // reset pulse while a fetch read is in flight
    tick();
    drive_if(32'h10);
    @(negedge clk);
    check("x_if_ready", 32'(bus.if_ready), 32'h1);
    #1;
    idle();
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    @(negedge clk);
    check("x_if_rvalid", 32'(bus.if_rvalid), 32'h0);
    check("x_starve",    32'(dbg_starve_cnt), 32'h0);
    tick();
    drive_d(1'b0, 32'h20, 32'h0, 4'b0000);
    @(negedge clk);
    check("x_d_ready", 32'(bus.d_ready), 32'h1);
    tick();
    idle();
    @(negedge clk);
    check("x_d_rdata", bus.d_rdata, 32'h00220044);

    repeat (2) tick();
    $display("[TB] %0d tests run, %0d failed", tests_run, failed);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one synchronous single-port word-addressed RAM between the CPU instruction-fetch port and the load/store data port.
- Grants at most one access per cycle.
- Data port has priority by default; a starvation counter forces a fetch grant after a bounded wait.
- Read data returns with fixed 1-cycle latency to the port that issued the read. Sits between the cpu core and its unified memory.

Parameters:
- ADDR_WIDTH, 32, byte address width on both requester ports
- DATA_WIDTH, 32, data width; must be 32 (4 byte strobes)
- STARVE_LIMIT, 4, consecutive denied fetch cycles before fetch wins; legal range 1..15

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- if_req  in  1  fetch read request
- if_addr  in  ADDR_WIDTH  fetch byte address
- if_ready  out  1  fetch request accepted this cycle (combinational)
- if_rvalid  out  1  fetch read data valid
- if_rdata  out  DATA_WIDTH  fetch read data
- d_req  in  1  data request
- d_we  in  1  1 = write, 0 = read
- d_addr  in  ADDR_WIDTH  data byte address
- d_wdata  in  DATA_WIDTH  write data
- d_wstrb  in  4  byte write enables, bit i = byte lane i
- d_ready  out  1  data request accepted this cycle (combinational)
- d_rvalid  out  1  data read data valid (reads only)
- d_rdata  out  DATA_WIDTH  data read data
- mem_en  out  1  RAM access enable
- mem_we  out  4  RAM byte write enables
- mem_addr  out  ADDR_WIDTH-2  RAM word address
- mem_wdata  out  DATA_WIDTH  RAM write data
- mem_rdata  in  DATA_WIDTH  RAM read data, valid the cycle after mem_en with mem_we==0

Behaviour:
- Handshake:
  - A transfer is accepted when req && ready in the same cycle.
  - Requesters hold req, addr, wdata and we stable until accepted.
  - Responses have no backpressure.
- Arbitration (combinational on the current cycle):
  - Only one req high: that port is granted.
  - Both high and starve_cnt < STARVE_LIMIT: data is granted.
  - Both high and starve_cnt == STARVE_LIMIT: fetch is granted.
  - Neither high: no grant, mem_en = 0.
- starve_cnt (4 bits, reset 0), updated each cycle:
  - if_req && !if_ready: increment, saturating at STARVE_LIMIT.
  - Otherwise (fetch granted, or if_req low): clear to 0.
- Memory drive:
  - mem_en = any grant.
  - mem_addr = granted addr[ADDR_WIDTH-1:2]. Low 2 address bits are ignored; misaligned addresses are not trapped.
  - Fetch grant: mem_we = 0.
  - Data grant: mem_we = d_we ? d_wstrb : 4'b0; mem_wdata = d_wdata.
  - No grant: mem_we = 0, mem_addr = 0, mem_wdata = 0.
- Response tracking: register resp_owner ∈ {NONE, IF, D}, reset NONE.
  - Set to IF or D on an accepted read.
  - Set to NONE on an accepted write or an idle cycle.
  - resp_owner == IF: if_rvalid = 1, if_rdata = mem_rdata.
  - resp_owner == D: d_rvalid = 1, d_rdata = mem_rdata.
  - rdata of the non-owning port is forced to 0.
- Throughput:
  - Back-to-back accepts allowed every cycle: one issue plus one return in flight.
  - Write followed immediately by a read to the same word returns the new data (RAM write-first timing is not required; the write lands one cycle before the read samples).
- Write with d_wstrb == 0: accepted, mem_en = 1, mem_we = 0, no rvalid, RAM unchanged.
- Reset values: if_rvalid = d_rvalid = 0, if_rdata = d_rdata = 0, starve_cnt = 0, resp_owner = NONE. Combinational outputs are 0 while inputs are idle.
- Reset asserted mid-operation: any in-flight read response is dropped, so no rvalid appears after reset release. The first post-reset grant follows normal priority.

Test Plan:
- Fetch only, if_req = 1 at if_addr = 0x10 with RAM[4] = 0xDEADBEEF -> if_ready = 1 same cycle, mem_addr = 4, if_rvalid = 1 and if_rdata = 0xDEADBEEF next cycle, d_rvalid = 0.
- Data write d_addr = 0x20, d_wdata = 0x11223344, d_wstrb = 4'b0101, then data read at 0x20 with prior RAM = 0 -> mem_we = 4'b0101, no rvalid for the write, read returns 0x00220044 one cycle after accept.
- Both requesting continuously with STARVE_LIMIT = 4 -> d_ready on cycles 0..3 and if_ready on cycle 4, pattern repeating every 5 cycles; starve_cnt returns to 0 after the fetch grant.
- Alternating read grants IF, D, IF on consecutive cycles -> each rvalid appears on the matching port exactly one cycle later; the other port's rdata = 0.
- Data write with d_wstrb = 0 -> d_ready = 1, mem_we = 0, RAM contents unchanged, no rvalid.
- Fetch read accepted, then rst_n pulsed low before the next rising edge -> if_rvalid stays 0, starve_cnt = 0; after release a lone d_req is granted in the first cycle.
